// File: rtl/fft256_stg5.sv
// fft256_stg5: fifth stage of a 256-point radix-2^2 SDF FFT.
// It runs a radix-2 butterfly with an 8-deep feedback delay and scales the result by 1/2
// with rounding. On sub-block indices 12..15 of every 16 it applies a -j rotation.
module fft256_stg5 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RH    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int unsigned Depth = 8;
    localparam logic [WIDTH:0] RhVal = (RH != 0) ? (WIDTH+1)'(1) : '0;

    logic [7:0]       di_count_q, di_count_d;
    logic             sp_en_q, sp_en_d;
    logic [7:0]       sp_count_q, sp_count_d;
    logic             do_en_q, do_en_d;
    logic [WIDTH-1:0] do_re_q, do_re_d;
    logic [WIDTH-1:0] do_im_q, do_im_d;

    logic [WIDTH-1:0] dly_re_q [Depth];
    logic [WIDTH-1:0] dly_im_q [Depth];
    logic [WIDTH-1:0] dly_in_re, dly_in_im;
    logic [WIDTH-1:0] dly_out_re, dly_out_im;

    logic             bf;
    logic             mj;
    logic [WIDTH-1:0] y0_re, y0_im, y1_re, y1_im;
    logic [WIDTH-1:0] sp_re, sp_im;

    assign dly_out_re = dly_re_q[Depth-1];
    assign dly_out_im = dly_im_q[Depth-1];
    assign bf         = di_count_q[3];
    assign mj         = (sp_count_q[3:2] == 2'b11);

    // Butterfly on WIDTH+1 bits, then keep bits [WIDTH:1] (the shift by 1 and the truncation).
    // The sum cannot overflow, so the dropped top bit is always a copy of the sign.
    always_comb begin
        y0_re = WIDTH'(({dly_out_re[WIDTH-1], dly_out_re} + {di_re[WIDTH-1], di_re} + RhVal) >> 1);
        y0_im = WIDTH'(({dly_out_im[WIDTH-1], dly_out_im} + {di_im[WIDTH-1], di_im} + RhVal) >> 1);
        y1_re = WIDTH'(({dly_out_re[WIDTH-1], dly_out_re} - {di_re[WIDTH-1], di_re} + RhVal) >> 1);
        y1_im = WIDTH'(({dly_out_im[WIDTH-1], dly_out_im} - {di_im[WIDTH-1], di_im} + RhVal) >> 1);
    end

    // Route the data. The first half of each 16 fills the delay line.
    // The second half sends y0 to the output and feeds y1 back into the delay line.
    always_comb begin
        dly_in_re = di_re;
        dly_in_im = di_im;
        sp_re     = dly_out_re;
        sp_im     = dly_out_im;
        if (bf) begin
            dly_in_re = y1_re;
            dly_in_im = y1_im;
            sp_re     = y0_re;
            sp_im     = y0_im;
        end
    end

    // Feedback delay line: shifts every cycle, no reset needed
    always_ff @(posedge clock) begin
        dly_re_q[0] <= dly_in_re;
        dly_im_q[0] <= dly_in_im;
        for (int unsigned i = 1; i < Depth; i++) begin
            dly_re_q[i] <= dly_re_q[i-1];
            dly_im_q[i] <= dly_im_q[i-1];
        end
    end

    // Control next-state and output next-state. A frame start takes priority over the end of the previous frame.
    always_comb begin
        di_count_d = di_en ? di_count_q + 8'd1 : 8'd0;
        sp_en_d    = sp_en_q;
        if (di_en && (di_count_q == 8'd7)) begin
            sp_en_d = 1'b1;
        end else if (sp_count_q == 8'd255) begin
            sp_en_d = 1'b0;
        end
        sp_count_d = sp_en_q ? sp_count_q + 8'd1 : 8'd0;
        do_en_d    = sp_en_q;
        do_re_d    = mj ? sp_im : sp_re;
        do_im_d    = mj ? ({WIDTH{1'b0}} - sp_re) : sp_im;
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            di_count_q <= 8'd0;
            sp_en_q    <= 1'b0;
            sp_count_q <= 8'd0;
            do_en_q    <= 1'b0;
            do_re_q    <= '0;
            do_im_q    <= '0;
        end else begin
            di_count_q <= di_count_d;
            sp_en_q    <= sp_en_d;
            sp_count_q <= sp_count_d;
            do_en_q    <= do_en_d;
            do_re_q    <= do_re_d;
            do_im_q    <= do_im_d;
        end
    end

    assign do_en = do_en_q;
    assign do_re = do_re_q;
    assign do_im = do_im_q;

endmodule

// File: tb/tb_fft256_stg5.sv
// tb_fft256_stg5: directed-vector bench for fft256_stg5 (RH=0 and RH=1 instances).
module tb_fft256_stg5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        di_en = 1'b0;
    logic [15:0] di_re = '0;
    logic [15:0] di_im = '0;
    logic        do_en0, do_en1;
    logic [15:0] do_re0, do_im0, do_re1, do_im1;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] in_re [256];
    logic [15:0] in_im [256];
    logic [15:0] e_re  [768];
    logic [15:0] e_im  [768];
    logic [15:0] o_re0 [768];
    logic [15:0] o_im0 [768];
    logic [15:0] o_re1 [768];
    logic [15:0] o_im1 [768];
    int first_hi, last_hi, n_hi;

    fft256_stg5 #(.WIDTH(16), .RH(0)) dut (
        .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .do_en(do_en0), .do_re(do_re0), .do_im(do_im0)
    );

    fft256_stg5 #(.WIDTH(16), .RH(1)) dut_rh1 (
        .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .do_en(do_en1), .do_re(do_re1), .do_im(do_im1)
    );

    always #5 clock = ~clock;

    task automatic idle(input int n);
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 256; i++) begin
            in_re[i] = '0;
            in_im[i] = '0;
        end
        for (int i = 0; i < 768; i++) begin
            e_re[i] = '0;
            e_im[i] = '0;
        end
    endtask

    // Drive nf back-to-back frames of in_* and capture every do_en=1 cycle
    task automatic run(input int nf);
        first_hi = -1;
        last_hi  = -1;
        n_hi     = 0;
        for (int i = 0; i < 768; i++) begin
            o_re0[i] = 'x; o_im0[i] = 'x; o_re1[i] = 'x; o_im1[i] = 'x;
        end
        for (int c = 0; c < nf * 256 + 16; c++) begin
            if (c < nf * 256) begin
                di_en = 1'b1;
                di_re = in_re[c % 256];
                di_im = in_im[c % 256];
            end else begin
                di_en = 1'b0;
                di_re = '0;
                di_im = '0;
            end
            @(posedge clock);
            #1;
            if (do_en0) begin
                if (first_hi < 0) first_hi = c + 1;
                if (n_hi < 768) begin
                    o_re0[n_hi] = do_re0; o_im0[n_hi] = do_im0;
                    o_re1[n_hi] = do_re1; o_im1[n_hi] = do_im1;
                end
                n_hi++;
                last_hi = c + 1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (do_en0 !== 1'b0) begin n_err++; $display("FAIL reset do_en: got %b want 0", do_en0); end
        n_cmp++; if (do_re0 !== 16'd0) begin n_err++; $display("FAIL reset do_re: got %0d want 0", do_re0); end
        n_cmp++; if (do_im0 !== 16'd0) begin n_err++; $display("FAIL reset do_im: got %0d want 0", do_im0); end
        n_cmp++; if (do_en1 !== 1'b0) begin n_err++; $display("FAIL reset rh1 do_en: got %b want 0", do_en1); end
        reset = 1'b0;
        idle(4);
    endtask

    task automatic test_impulse(input string tag);
        idle(4);
        clear_vec();
        in_re[4] = 16'd1000;
        e_re[4]  = 16'd500;
        e_im[12] = 16'(-500);
        run(1);
        n_cmp++; if (first_hi !== 9) begin n_err++; $display("FAIL %s first do_en: got cycle %0d want 9", tag, first_hi); end
        n_cmp++; if (n_hi !== 256) begin n_err++; $display("FAIL %s do_en length: got %0d want 256", tag, n_hi); end
        n_cmp++; if (last_hi - first_hi + 1 !== n_hi) begin n_err++; $display("FAIL %s do_en gap: span %0d want %0d", tag, last_hi - first_hi + 1, n_hi); end
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (o_re0[i] !== e_re[i] || o_im0[i] !== e_im[i]) begin
                n_err++;
                $display("FAIL %s idx %0d: got (%0d,%0d) want (%0d,%0d)", tag, i,
                         $signed(o_re0[i]), $signed(o_im0[i]), $signed(e_re[i]), $signed(e_im[i]));
            end
        end
    endtask

    task automatic test_constant();
        idle(4);
        clear_vec();
        for (int i = 0; i < 256; i++) begin
            in_re[i] = 16'd100;
            in_im[i] = 16'd50;
            if ((i & 8) == 0) begin
                e_re[i] = 16'd100;
                e_im[i] = 16'd50;
            end
        end
        run(1);
        n_cmp++; if (n_hi !== 256) begin n_err++; $display("FAIL constant do_en length: got %0d want 256", n_hi); end
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (o_re0[i] !== e_re[i] || o_im0[i] !== e_im[i]) begin
                n_err++;
                $display("FAIL constant idx %0d: got (%0d,%0d) want (%0d,%0d)", i,
                         $signed(o_re0[i]), $signed(o_im0[i]), $signed(e_re[i]), $signed(e_im[i]));
            end
        end
    endtask

    task automatic test_rounding();
        idle(4);
        clear_vec();
        in_re[0] = 16'd3;
        in_im[0] = 16'(-3);
        e_re[0] = 16'd1; e_im[0] = 16'(-2);
        e_re[8] = 16'd1; e_im[8] = 16'(-2);
        run(1);
        n_cmp++; if (n_hi !== 256) begin n_err++; $display("FAIL rounding do_en length: got %0d want 256", n_hi); end
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (o_re0[i] !== e_re[i] || o_im0[i] !== e_im[i]) begin
                n_err++;
                $display("FAIL rounding rh0 idx %0d: got (%0d,%0d) want (%0d,%0d)", i,
                         $signed(o_re0[i]), $signed(o_im0[i]), $signed(e_re[i]), $signed(e_im[i]));
            end
        end
        // RH=1: (3+1)>>1 = 2, (-3+1)>>1 = -1 for both y0 and y1; zeros stay zero
        e_re[0] = 16'd2; e_im[0] = 16'(-1);
        e_re[8] = 16'd2; e_im[8] = 16'(-1);
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (o_re1[i] !== e_re[i] || o_im1[i] !== e_im[i]) begin
                n_err++;
                $display("FAIL rounding rh1 idx %0d: got (%0d,%0d) want (%0d,%0d)", i,
                         $signed(o_re1[i]), $signed(o_im1[i]), $signed(e_re[i]), $signed(e_im[i]));
            end
        end
    endtask

    task automatic test_minus_j();
        for (int s = 0; s < 3; s++) begin
            idle(4);
            clear_vec();
            case (s)
                0: begin
                    // y0 = (0 + -32768)/2, y1 = (0 - -32768)/2 = 16384 then rotated
                    in_re[12] = 16'h8000; in_im[12] = 16'h8000;
                    in_re[13] = 16'h8000; in_im[13] = 16'h8000;
                    e_re[4]  = 16'(-16384); e_im[4]  = 16'(-16384);
                    e_re[5]  = 16'(-16384); e_im[5]  = 16'(-16384);
                    e_re[12] = 16'd16384;   e_im[12] = 16'(-16384);
                    e_re[13] = 16'd16384;   e_im[13] = 16'(-16384);
                end
                1: begin
                    in_re[4] = 16'h8000;
                    e_re[4]  = 16'(-16384);
                    e_im[12] = 16'd16384;
                end
                default: begin
                    // y1 re = (-32768 - 32767) >> 1 = -32768; negation wraps to -32768
                    in_re[4]  = 16'h8000;
                    in_re[12] = 16'h7fff;
                    e_re[4]   = 16'hffff;
                    e_im[12]  = 16'h8000;
                end
            endcase
            run(1);
            n_cmp++; if (n_hi !== 256) begin n_err++; $display("FAIL minus_j case %0d do_en length: got %0d want 256", s, n_hi); end
            for (int i = 0; i < 256; i++) begin
                n_cmp++;
                if (o_re0[i] !== e_re[i] || o_im0[i] !== e_im[i]) begin
                    n_err++;
                    $display("FAIL minus_j case %0d idx %0d: got (%0d,%0d) want (%0d,%0d)", s, i,
                             $signed(o_re0[i]), $signed(o_im0[i]), $signed(e_re[i]), $signed(e_im[i]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        idle(4);
        clear_vec();
        in_re[0] = 16'd200;
        for (int f = 0; f < 3; f++) begin
            e_re[f * 256]     = 16'd100;
            e_re[f * 256 + 8] = 16'd100;
        end
        run(3);
        n_cmp++; if (first_hi !== 9) begin n_err++; $display("FAIL b2b first do_en: got cycle %0d want 9", first_hi); end
        n_cmp++; if (n_hi !== 768) begin n_err++; $display("FAIL b2b do_en length: got %0d want 768", n_hi); end
        n_cmp++; if (last_hi - first_hi + 1 !== n_hi) begin n_err++; $display("FAIL b2b do_en gap: span %0d want %0d", last_hi - first_hi + 1, n_hi); end
        for (int i = 0; i < 768; i++) begin
            n_cmp++;
            if (o_re0[i] !== e_re[i] || o_im0[i] !== e_im[i]) begin
                n_err++;
                $display("FAIL b2b idx %0d: got (%0d,%0d) want (%0d,%0d)", i,
                         $signed(o_re0[i]), $signed(o_im0[i]), $signed(e_re[i]), $signed(e_im[i]));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        idle(4);
        clear_vec();
        in_re[4] = 16'd1000;
        for (int c = 0; c <= 100; c++) begin
            di_en = 1'b1;
            di_re = in_re[c];
            di_im = in_im[c];
            if (c < 100) begin
                @(posedge clock);
                #1;
            end
        end
        n_cmp++; if (do_en0 !== 1'b1) begin n_err++; $display("FAIL midreset pre do_en: got %b want 1", do_en0); end
        reset = 1'b1;
        #1;
        n_cmp++; if (do_en0 !== 1'b0) begin n_err++; $display("FAIL midreset async do_en: got %b want 0", do_en0); end
        n_cmp++; if (do_im0 !== 16'd0 || do_re0 !== 16'd0) begin n_err++; $display("FAIL midreset async data: got (%0d,%0d) want (0,0)", do_re0, do_im0); end
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            n_cmp++; if (do_en0 !== 1'b0) begin n_err++; $display("FAIL midreset idle do_en cycle %0d: got %b want 0", c, do_en0); end
        end
        test_impulse("post_reset");
    endtask

    initial begin
        test_reset();
        test_impulse("impulse");
        test_constant();
        test_rounding();
        test_minus_j();
        test_back_to_back();
        test_reset_mid_frame();
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
